// File: rtl/ddr_para_init_ctrl.sv
// ----------------------------------------------------------------------------
// ddr_para_init_ctrl
//
// Purpose:
//   Runs the DDR parameter-initialisation transfer one segment at a time. Each
//   start/continue pulse moves SEG_WORDS words from the host parameter stream
//   into DDR through a MIG-style user interface. Each word is one single-beat
//   write command. The DDR address carries over from segment to segment. After
//   NUM_SEGS segments the block holds init_done high until reset.
//
// Ports:
//   sys_clk_200M        in   system clock, rising edge
//   sys_rst_n           in   asynchronous active-low reset
//   sync_init_cont_sig  in   one-cycle start/continue pulse
//   init_calib_complete in   DDR calibration done (level)
//   para_data/valid     in   parameter stream word and its valid
//   para_ready          out  stream ready (high in FETCH only)
//   app_en/cmd/addr     out  MIG command channel (write only)
//   app_rdy             in   command accepted
//   app_wdf_data/wren/end out MIG write-data channel (single-beat bursts)
//   app_wdf_rdy         in   write data accepted
//   init_busy           out  segment in progress
//   seg_done            out  one-cycle pulse at the end of each segment
//   init_done           out  all segments written (level)
//   pulse_ovr           out  sticky: start pulse seen while not idle
// ----------------------------------------------------------------------------
module ddr_para_init_ctrl #(
    parameter int DATA_W    = 512,
    parameter int ADDR_W    = 29,
    parameter int BASE_ADDR = 0,
    parameter int ADDR_STEP = 8,
    parameter int SEG_WORDS = 1024,
    parameter int NUM_SEGS  = 4
) (
    input  logic              sys_clk_200M,
    input  logic              sys_rst_n,
    input  logic              sync_init_cont_sig,
    input  logic              init_calib_complete,
    input  logic [DATA_W-1:0] para_data,
    input  logic              para_valid,
    output logic              para_ready,
    output logic              app_en,
    output logic [2:0]        app_cmd,
    output logic [ADDR_W-1:0] app_addr,
    input  logic              app_rdy,
    output logic [DATA_W-1:0] app_wdf_data,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    input  logic              app_wdf_rdy,
    output logic              init_busy,
    output logic              seg_done,
    output logic              init_done,
    output logic              pulse_ovr
);

    localparam int WC_W = $clog2(SEG_WORDS + 1);
    localparam int SC_W = $clog2(NUM_SEGS + 1);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);
    localparam logic [WC_W-1:0]   LAST_WORD = WC_W'(SEG_WORDS - 1);
    localparam logic [SC_W-1:0]   LAST_SEG  = SC_W'(NUM_SEGS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_CAL = 3'd1,
        FETCH    = 3'd2,
        WRITE    = 3'd3,
        SEG_END  = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [WC_W-1:0]     r_word_cnt;
    logic [SC_W-1:0]     r_seg_cnt;
    logic                r_cmd_ok;
    logic                r_dat_ok;
    logic                r_ovr;

    logic w_in_write;
    logic w_cmd_acc;
    logic w_dat_acc;
    logic w_beat_done;
    logic w_capture;

    // Each channel is offered until its own handshake, independently of the
    // other; the beat completes once both sides have been taken.
    assign w_in_write  = (r_state == WRITE);
    assign w_cmd_acc   = w_in_write && !r_cmd_ok && app_rdy;
    assign w_dat_acc   = w_in_write && !r_dat_ok && app_wdf_rdy;
    assign w_beat_done = w_in_write && (r_cmd_ok || w_cmd_acc) && (r_dat_ok || w_dat_acc);
    assign w_capture   = (r_state == FETCH) && para_valid;

    assign para_ready   = (r_state == FETCH);
    assign app_en       = w_in_write && !r_cmd_ok;
    assign app_wdf_wren = w_in_write && !r_dat_ok;
    assign app_wdf_end  = app_wdf_wren;
    assign app_cmd      = 3'b000;
    assign app_addr     = r_addr;
    assign app_wdf_data = r_wdata;
    assign init_busy    = (r_state == WAIT_CAL) || (r_state == FETCH) ||
                          (r_state == WRITE)    || (r_state == SEG_END);
    assign seg_done     = (r_state == SEG_END);
    assign init_done    = (r_state == DONE);
    assign pulse_ovr    = r_ovr;

    always_ff @(posedge sys_clk_200M or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (sync_init_cont_sig) w_next = WAIT_CAL;
            WAIT_CAL: if (init_calib_complete) w_next = FETCH;
            FETCH:    if (para_valid) w_next = WRITE;
            WRITE: begin
                if (w_beat_done) begin
                    w_next = (r_word_cnt == LAST_WORD) ? SEG_END : FETCH;
                end
            end
            SEG_END:  w_next = (r_seg_cnt == LAST_SEG) ? DONE : IDLE;
            DONE:     w_next = DONE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_200M or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_addr     <= BASE;
            r_wdata    <= '0;
            r_word_cnt <= '0;
            r_seg_cnt  <= '0;
            r_cmd_ok   <= 1'b0;
            r_dat_ok   <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            // Only an idle controller accepts a start; anything else is an
            // overrun, including a pulse coincident with SEG_END -> IDLE.
            if (sync_init_cont_sig && (r_state != IDLE)) begin
                r_ovr <= 1'b1;
            end

            if (w_capture) begin
                r_wdata <= para_data;
            end

            if (w_beat_done) begin
                r_addr     <= r_addr + STEP;
                r_word_cnt <= r_word_cnt + 1'b1;
                r_cmd_ok   <= 1'b0;
                r_dat_ok   <= 1'b0;
            end else begin
                if (w_cmd_acc) r_cmd_ok <= 1'b1;
                if (w_dat_acc) r_dat_ok <= 1'b1;
            end

            // Address is deliberately kept so the next segment continues on.
            if (r_state == SEG_END) begin
                r_word_cnt <= '0;
                r_seg_cnt  <= r_seg_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr_para_init_ctrl.sv
`timescale 1ns/1ps
module tb_ddr_para_init_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pulse0 = 1'b0;
    logic        pulse1 = 1'b0;
    logic        cal = 1'b0;
    logic        pvalid = 1'b0;
    logic        app_rdy = 1'b0;
    logic        wdf_rdy = 1'b0;
    logic [31:0] idx = 32'd0;
    logic [31:0] pdata;

    logic        para_ready, app_en, wren, wend, busy, seg_done, init_done, ovr;
    logic [2:0]  app_cmd;
    logic [28:0] app_addr;
    logic [31:0] wdata;

    logic        para_ready1, app_en1, wren1, wend1, busy1, seg_done1, init_done1, ovr1;
    logic [2:0]  app_cmd1;
    logic [5:0]  app_addr1;
    logic [7:0]  wdata1;

    int checks = 0;
    int errors = 0;
    int segdone_cnt = 0;
    logic [31:0] cmd_q[$];
    logic [31:0] dat_q[$];
    logic [31:0] cmd1_q[$];

    always #5 clk = ~clk;

    assign pdata = 32'hA000_0000 + idx;

    ddr_para_init_ctrl #(
        .DATA_W(32), .ADDR_W(29), .BASE_ADDR(32'h100), .ADDR_STEP(8),
        .SEG_WORDS(4), .NUM_SEGS(2)
    ) u0 (
        .sys_clk_200M(clk), .sys_rst_n(rst_n), .sync_init_cont_sig(pulse0),
        .init_calib_complete(cal), .para_data(pdata), .para_valid(pvalid),
        .para_ready(para_ready), .app_en(app_en), .app_cmd(app_cmd),
        .app_addr(app_addr), .app_rdy(app_rdy), .app_wdf_data(wdata),
        .app_wdf_wren(wren), .app_wdf_end(wend), .app_wdf_rdy(wdf_rdy),
        .init_busy(busy), .seg_done(seg_done), .init_done(init_done),
        .pulse_ovr(ovr)
    );

    ddr_para_init_ctrl #(
        .DATA_W(8), .ADDR_W(6), .BASE_ADDR(56), .ADDR_STEP(8),
        .SEG_WORDS(2), .NUM_SEGS(1)
    ) u1 (
        .sys_clk_200M(clk), .sys_rst_n(rst_n), .sync_init_cont_sig(pulse1),
        .init_calib_complete(1'b1), .para_data(8'h5A), .para_valid(1'b1),
        .para_ready(para_ready1), .app_en(app_en1), .app_cmd(app_cmd1),
        .app_addr(app_addr1), .app_rdy(1'b1), .app_wdf_data(wdata1),
        .app_wdf_wren(wren1), .app_wdf_end(wend1), .app_wdf_rdy(1'b1),
        .init_busy(busy1), .seg_done(seg_done1), .init_done(init_done1),
        .pulse_ovr(ovr1)
    );

    // Record accepted commands / data beats and advance the parameter stream.
    always @(posedge clk) begin
        if (rst_n && app_en && app_rdy) cmd_q.push_back({3'b000, app_addr});
        if (rst_n && wren && wdf_rdy) dat_q.push_back(wdata);
        if (rst_n && seg_done) segdone_cnt++;
        if (rst_n && app_en1) cmd1_q.push_back({26'd0, app_addr1});
        if (pvalid && para_ready) idx <= idx + 32'd1;
    end

    task automatic pulse(input int which);
        @(negedge clk);
        if (which == 0) pulse0 = 1'b1; else pulse1 = 1'b1;
        @(negedge clk);
        pulse0 = 1'b0;
        pulse1 = 1'b0;
    endtask

    task automatic wait_seg(output bit ok);
        int n = 0;
        while (!seg_done && n < 300) begin
            @(negedge clk);
            n++;
        end
        ok = seg_done;
    endtask

    task automatic test_reset();
        #12;
        checks++; if ({para_ready, app_en, wren, wend, busy, seg_done, init_done, ovr} !== 8'h00) begin
            errors++; $display("FAIL reset_outputs: got %b want 00000000",
                {para_ready, app_en, wren, wend, busy, seg_done, init_done, ovr});
        end
        checks++; if (app_cmd !== 3'b000 || wdata !== 32'd0) begin
            errors++; $display("FAIL reset_cmd_data: cmd %0h data %0h want 0 0", app_cmd, wdata);
        end
        checks++; if ({busy1, init_done1, app_en1} !== 3'b000) begin
            errors++; $display("FAIL reset_u1: got %b want 000", {busy1, init_done1, app_en1});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        int n = 0;
        cmd1_q.delete();
        pulse(1);
        while (!seg_done1 && n < 100) begin @(negedge clk); n++; end
        checks++; if (seg_done1 !== 1'b1) begin
            errors++; $display("FAIL wrap_seg_done: got %b want 1", seg_done1);
        end
        @(negedge clk);
        checks++; if (cmd1_q.size() != 2) begin
            errors++; $display("FAIL wrap_count: got %0d want 2", cmd1_q.size());
        end else begin
            checks++; if (cmd1_q[0] !== 32'd56 || cmd1_q[1] !== 32'd0) begin
                errors++; $display("FAIL wrap_addr: got %0d,%0d want 56,0", cmd1_q[0], cmd1_q[1]);
            end
        end
        checks++; if (init_done1 !== 1'b1 || ovr1 !== 1'b0) begin
            errors++; $display("FAIL wrap_flags: done %b ovr %b want 1 0", init_done1, ovr1);
        end
    endtask

    task automatic test_first_segment();
        bit ok;
        cal = 1'b1; pvalid = 1'b1; app_rdy = 1'b1; wdf_rdy = 1'b1;
        cmd_q.delete(); dat_q.delete(); segdone_cnt = 0;
        pulse(0);
        checks++; if (busy !== 1'b1 || para_ready !== 1'b0) begin
            errors++; $display("FAIL seg1_wait_cal: busy %b ready %b want 1 0", busy, para_ready);
        end
        @(negedge clk);
        checks++; if (para_ready !== 1'b1) begin
            errors++; $display("FAIL seg1_ready_latency: got %b want 1", para_ready);
        end
        wait_seg(ok);
        checks++; if (!ok) begin errors++; $display("FAIL seg1_timeout: seg_done 0 want 1"); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || init_done !== 1'b0 || segdone_cnt != 1) begin
            errors++; $display("FAIL seg1_end: busy %b done %b pulses %0d want 0 0 1", busy, init_done, segdone_cnt);
        end
        checks++; if (cmd_q.size() != 4 || dat_q.size() != 4) begin
            errors++; $display("FAIL seg1_beats: cmd %0d dat %0d want 4 4", cmd_q.size(), dat_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++; if (cmd_q[k] !== 32'h100 + 32'(8 * k) || dat_q[k] !== 32'hA000_0000 + 32'(k)) begin
                    errors++; $display("FAIL seg1_beat%0d: addr %0h data %0h want %0h %0h", k, cmd_q[k], dat_q[k],
                        32'h100 + 32'(8 * k), 32'hA000_0000 + 32'(k));
                end
            end
        end
    endtask

    task automatic test_cal_delay_and_overrun();
        bit ok;
        int rdy_seen = 0;
        int n = 0;
        cmd_q.delete(); dat_q.delete();
        cal = 1'b0;
        pulse(0);
        for (int i = 0; i < 10; i++) begin
            if (para_ready) rdy_seen++;
            @(negedge clk);
        end
        cal = 1'b1;
        checks++; if (rdy_seen != 0 || para_ready !== 1'b0) begin
            errors++; $display("FAIL cal_hold: ready cycles %0d want 0", rdy_seen);
        end
        @(negedge clk);
        checks++; if (para_ready !== 1'b1) begin
            errors++; $display("FAIL cal_ready_latency: got %b want 1", para_ready);
        end
        while (cmd_q.size() < 2 && n < 100) begin @(negedge clk); n++; end
        checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL ovr_before: got %b want 0", ovr); end
        pulse(0);
        checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL ovr_mid_seg: got %b want 1", ovr); end
        wait_seg(ok);
        checks++; if (!ok) begin errors++; $display("FAIL seg2_timeout: seg_done 0 want 1"); end
        @(negedge clk);
        checks++; if (init_done !== 1'b1 || ovr !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL seg2_end: done %b ovr %b busy %b want 1 1 0", init_done, ovr, busy);
        end
        checks++; if (cmd_q.size() != 4 || dat_q.size() != 4) begin
            errors++; $display("FAIL seg2_beats: cmd %0d dat %0d want 4 4", cmd_q.size(), dat_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++; if (cmd_q[k] !== 32'h120 + 32'(8 * k) || dat_q[k] !== 32'hA000_0004 + 32'(k)) begin
                    errors++; $display("FAIL seg2_beat%0d: addr %0h data %0h want %0h %0h", k, cmd_q[k], dat_q[k],
                        32'h120 + 32'(8 * k), 32'hA000_0004 + 32'(k));
                end
            end
        end
    endtask

    task automatic test_pulse_after_done();
        int n0 = cmd_q.size();
        pulse(0);
        repeat (20) @(negedge clk);
        checks++; if (cmd_q.size() != n0 || init_done !== 1'b1 || busy !== 1'b0 || para_ready !== 1'b0) begin
            errors++; $display("FAIL after_done: cmds %0d done %b busy %b ready %b want %0d 1 0 0",
                cmd_q.size(), init_done, busy, para_ready, n0);
        end
        checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL after_done_ovr: got %b want 1", ovr); end
    endtask

    task automatic test_cmd_stall();
        bit ok;
        int n = 0;
        int en_cycles = 0;
        int bad_addr = 0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        checks++; if (ovr !== 1'b0 || init_done !== 1'b0) begin
            errors++; $display("FAIL stall_reset: ovr %b done %b want 0 0", ovr, init_done);
        end
        cmd_q.delete(); dat_q.delete();
        app_rdy = 1'b0;
        pulse(0);
        while (!app_en && n < 50) begin @(negedge clk); n++; end
        checks++; if (app_en !== 1'b1 || wren !== 1'b1 || wend !== 1'b1) begin
            errors++; $display("FAIL stall_start: en %b wren %b end %b want 1 1 1", app_en, wren, wend);
        end
        for (int i = 0; i <= 5; i++) begin
            if (app_en) en_cycles++;
            if (app_addr !== 29'h100) bad_addr++;
            if (i == 1) begin
                checks++; if (wren !== 1'b0) begin errors++; $display("FAIL stall_wren_drop: got %b want 0", wren); end
            end
            if (i == 5) app_rdy = 1'b1;
            @(negedge clk);
        end
        checks++; if (en_cycles != 6 || bad_addr != 0 || app_en !== 1'b0) begin
            errors++; $display("FAIL stall_en_hold: cycles %0d bad_addr %0d en_after %b want 6 0 0",
                en_cycles, bad_addr, app_en);
        end
        checks++; if (cmd_q.size() != 1 || dat_q.size() != 1) begin
            errors++; $display("FAIL stall_single_beat: cmd %0d dat %0d want 1 1", cmd_q.size(), dat_q.size());
        end
        wait_seg(ok);
        @(negedge clk);
        checks++; if (!ok || cmd_q.size() != 4 || dat_q.size() != 4) begin
            errors++; $display("FAIL stall_seg: done %b cmd %0d dat %0d want 1 4 4", ok, cmd_q.size(), dat_q.size());
        end else begin
            checks++; if (cmd_q[1] !== 32'h108 || cmd_q[3] !== 32'h118 || dat_q[3] !== dat_q[0] + 32'd3) begin
                errors++; $display("FAIL stall_seq: a1 %0h a3 %0h d0 %0h d3 %0h want 108 118 d0+3",
                    cmd_q[1], cmd_q[3], dat_q[0], dat_q[3]);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        bit ok;
        int n = 0;
        int n_cmd;
        cmd_q.delete();
        pulse(0);
        while (!(app_en && app_addr == 29'h130) && n < 100) begin @(negedge clk); n++; end
        checks++; if (app_en !== 1'b1 || app_addr !== 29'h130) begin
            errors++; $display("FAIL rst_reach_word2: en %b addr %0h want 1 130", app_en, app_addr);
        end
        n_cmd = cmd_q.size();
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({para_ready, app_en, wren, wend, busy, seg_done, init_done, ovr} !== 8'h00 || wdata !== 32'd0) begin
            errors++; $display("FAIL rst_async_outputs: got %b data %0h want 00000000 0",
                {para_ready, app_en, wren, wend, busy, seg_done, init_done, ovr}, wdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (cmd_q.size() != n_cmd) begin
            errors++; $display("FAIL rst_no_beat: cmds %0d want %0d", cmd_q.size(), n_cmd);
        end
        cmd_q.delete();
        pulse(0);
        wait_seg(ok);
        @(negedge clk);
        checks++; if (!ok || cmd_q.size() != 4) begin
            errors++; $display("FAIL rst_restart_seg: done %b cmds %0d want 1 4", ok, cmd_q.size());
        end else begin
            checks++; if (cmd_q[0] !== 32'h100 || cmd_q[3] !== 32'h118) begin
                errors++; $display("FAIL rst_restart_addr: a0 %0h a3 %0h want 100 118", cmd_q[0], cmd_q[3]);
            end
        end
        checks++; if (init_done !== 1'b0) begin
            errors++; $display("FAIL rst_restart_seg0: init_done %b want 0", init_done);
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_first_segment();
        test_cal_delay_and_overrun();
        test_pulse_after_done();
        test_cmd_stall();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr_para_init_ctrl.md
Name: ddr_para_init_ctrl

Overview:
- Consumes the single-cycle init/continue pulse from the synchroniser stage and runs one segment of the DDR parameter-initialisation transfer per pulse.
- Each segment takes SEG_WORDS words from the host-side parameter stream and writes them to DDR through the MIG-style user interface, one beat per write command.
- The DDR address continues from one segment to the next. After NUM_SEGS segments the block reports completion to the accelerator top.

Parameters:
- DATA_W, 512, width of a parameter word and of the DDR write beat.
- ADDR_W, 29, DDR user address width.
- BASE_ADDR, 0, first DDR address written after reset.
- ADDR_STEP, 8, address increment per beat (BL8).
- SEG_WORDS, 1024, words written per init/continue pulse (≥1).
- NUM_SEGS, 4, segments per full initialisation (≥1).

Ports:
- sys_clk_200M  in  1  system clock, all logic rising-edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- sync_init_cont_sig  in  1  one-cycle start/continue pulse.
- init_calib_complete  in  1  DDR calibration done (level).
- para_data  in  DATA_W  parameter word.
- para_valid  in  1  para_data valid.
- para_ready  out  1  word accepted when para_valid & para_ready.
- app_en  out  1  command valid.
- app_cmd  out  3  command, constant 3'b000 (write).
- app_addr  out  ADDR_W  command address.
- app_rdy  in  1  command accepted when app_en & app_rdy.
- app_wdf_data  out  DATA_W  write data.
- app_wdf_wren  out  1  write data valid.
- app_wdf_end  out  1  equals app_wdf_wren (single-beat burst).
- app_wdf_rdy  in  1  data accepted when app_wdf_wren & app_wdf_rdy.
- init_busy  out  1  segment in progress.
- seg_done  out  1  one-cycle pulse at the end of each segment.
- init_done  out  1  level, high after all segments are written.
- pulse_ovr  out  1  sticky: a start pulse arrived while busy or after done.

Behaviour:

Reset:
- All outputs are 0 at reset.
- app_addr = BASE_ADDR, segment counter = 0, word counter = 0, state IDLE.
- Reset mid-transfer aborts immediately. No beat is completed, and the next pulse restarts at BASE_ADDR, segment 0.

FSM states: IDLE, WAIT_CAL, FETCH, WRITE, SEG_END, DONE.
- IDLE: a sync_init_cont_sig pulse goes to WAIT_CAL.
- WAIT_CAL: moves to FETCH on the first cycle init_calib_complete=1. With calibration already high, FETCH is entered 2 cycles after the pulse cycle (IDLE→WAIT_CAL→FETCH).
- FETCH:
  - para_ready=1.
  - On a handshake, register para_data into app_wdf_data and go to WRITE.
  - para_ready is combinationally (state==FETCH). At most one word is buffered.
- WRITE:
  - app_en and app_wdf_wren assert in the cycle after capture, with the current app_addr.
  - Command and data acceptance are tracked by independent flags cmd_ok and dat_ok.
  - app_en drops the cycle after app_rdy is seen. app_wdf_wren drops the cycle after app_wdf_rdy is seen. Either may be accepted first, or both in the same cycle.
  - Once both are accepted: app_addr += ADDR_STEP (wraps modulo 2^ADDR_W), word counter +1, flags clear.
  - If word counter reaches SEG_WORDS, go to SEG_END. Otherwise go to FETCH.
- SEG_END:
  - seg_done=1 for one cycle, word counter := 0, segment counter +1.
  - If segment counter reaches NUM_SEGS, go to DONE. Otherwise go to IDLE.
  - app_addr is retained for the next segment.
- DONE: init_done=1 and held until reset. Further pulses are ignored.

init_busy:
- Asserted from the cycle after the pulse in IDLE through the SEG_END cycle inclusive.

Start pulse while not in IDLE:
- A pulse arriving in WAIT_CAL, FETCH, WRITE, SEG_END or DONE is ignored and sets pulse_ovr.
- pulse_ovr is cleared only by reset.
- A pulse in the same cycle as the SEG_END→IDLE transition counts as overrun. It is not queued.

Stream and DDR stalls:
- para_valid low holds FETCH indefinitely.
- app_rdy or app_wdf_rdy low holds WRITE indefinitely.
- While stalled, outputs stay stable and app_addr and app_wdf_data do not change.
- Calibration dropping during WRITE is ignored. It is only checked in WAIT_CAL.

Test Plan:
- SEG_WORDS=4, NUM_SEGS=2, BASE_ADDR=0x100, rdy signals tied 1, para_valid tied 1; pulse → 4 writes at 0x100, 0x108, 0x110, 0x118, seg_done once, init_busy drops, init_done=0. Second pulse → writes at 0x120–0x138, then init_done=1.
- app_rdy held 0 for 5 cycles while app_wdf_rdy=1 → app_wdf_wren drops after 1 cycle, app_en held 6 cycles, single address increment, no lost or duplicated beat.
- init_calib_complete=0 at pulse, raised 10 cycles later → para_ready first asserts 1 cycle after calibration rises. Pulse with calibration already high → para_ready asserts 2 cycles after the pulse.
- Second pulse issued mid-segment → transfer unaffected, pulse_ovr=1 and sticky. Pulse after init_done → no new writes, pulse_ovr=1.
- sys_rst_n asserted during WRITE of word 2 → all outputs 0 asynchronously. Next pulse restarts at BASE_ADDR, segment 0.
- ADDR_W=6, BASE_ADDR=56, ADDR_STEP=8, SEG_WORDS=2 → addresses 56 then 0 (wrap), no error flag.
